simmem_rsp_bank_gen: RTL and testbench
======================================

Name: simmem_rsp_bank_gen

Overview:
Parametrised response bank for the simulated memory controller. One generic block replaces the separate write-response and read-data banks; instances differ only in parameters. It reserves per-burst storage entries, accepts responses from the real controller in per-AXI-ID order, and holds them. It emits them beat-by-beat only once the delay releaser has enabled each entry. Entries are released out of order across IDs, but bursts are never interleaved on the output.

Parameters:
- NumIds, 4, number of AXI IDs; IdW = max(1, clog2(NumIds)).
- Capacity, 8, number of burst entries; IidW = max(1, clog2(Capacity)).
- MaxBurstLen, 4, beats per entry. Use 1 for write-response instances.
- BurstLenW, max(1, clog2(MaxBurstLen)), width of the burst-length field. Encoded length = beats - 1.
- DataW, 32, payload width per beat, excluding handshake.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- rsv_valid_i  in  1  reservation request
- rsv_ready_o  out  1  a free entry exists
- rsv_id_i  in  IdW  AXI ID of the reserved burst
- rsv_burst_len_i  in  BurstLenW  beats - 1 (ignored and taken as 0 when MaxBurstLen=1)
- rsv_iid_o  out  IidW  allocated entry index (internal identifier)
- release_en_i  in  Capacity  multi-hot release enable, one bit per entry
- released_addr_onehot_o  out  Capacity  one-hot entry index of the beat sent this cycle
- in_valid_i  in  1  response beat from the controller
- in_ready_o  out  1  beat can be stored
- in_id_i  in  IdW  ID of the incoming beat
- in_data_i  in  DataW  incoming payload
- out_valid_o  out  1  released beat available
- out_ready_i  in  1  requester accepts the beat
- out_data_o  out  DataW  outgoing payload
- out_last_o  out  1  last beat of the burst
- free_cnt_o  out  IidW+1  number of free entries

Behaviour:
- Reset: all entries FREE; per-ID sequence counters rsv_seq/in_seq = 0; output lock cleared; free_cnt_o = Capacity.
- Reset outputs: rsv_ready_o = 1; in_ready_o = 0; out_valid_o = 0; out_last_o = 0; released_addr_onehot_o = 0.
- Reset mid-burst discards all stored data. No partial beat completes after reset.
- Per-entry state: FREE -> RESERVED (awaiting beats) -> FILLED (all beats stored) -> FREE (after last beat sent).
- Per-entry fields: id, seq, len, wr_ptr, rd_ptr.
- Reservation:
  - rsv_ready_o = any FREE entry.
  - rsv_iid_o = lowest-index FREE entry, combinational, valid whenever rsv_ready_o = 1.
  - On handshake, the entry records id, len and seq = rsv_seq[id]; rsv_seq[id] increments mod Capacity.
- Input:
  - in_ready_o = 1 iff some non-FREE entry with id == in_id_i and seq == in_seq[in_id_i] has wr_ptr <= len. Combinational on in_id_i.
  - A beat with no matching reservation is back-pressured, never dropped.
  - On handshake, data is written at [entry][wr_ptr] and wr_ptr increments.
  - On the last beat (wr_ptr == len): the entry becomes FILLED and in_seq[id] increments mod Capacity.
- Output eligibility: an entry is eligible when release_en_i[e] = 1 and rd_ptr < wr_ptr. Streaming is allowed before the entry is FILLED.
- Output arbitration:
  - If unlocked, pick the lowest-index eligible entry and lock it.
  - The lock holds until out_last_o is handshaken; no other entry's beats interleave.
  - While locked and the locked entry's next beat is not yet stored, out_valid_o = 0.
- Output signals:
  - out_data_o = data at [entry][rd_ptr].
  - out_last_o = (rd_ptr == len).
  - released_addr_onehot_o has bit e set only in the cycle of an out handshake.
- Freeing: on the out handshake with out_last_o = 1, the entry returns to FREE at the next edge. It is visible as free (rsv_ready_o, free_cnt_o) from the next cycle, never in the same cycle.
- Latency: a beat written at edge N can be output in the cycle after edge N, if released. Write-to-read path = 1 cycle.
- Simultaneous events in one cycle are all legal and act on independent state: reservation, input write and output read to the same entry, and output free of a different entry.
- Full: rsv_ready_o = 0; input and output continue.
- Empty: in_ready_o = 0 and out_valid_o = 0.
- Sequence counters wrap mod Capacity. They cannot alias, because at most Capacity bursts are outstanding.
- Width rules:
  - free_cnt_o = Capacity minus the number of non-FREE entries.
  - A length field > MaxBurstLen-1 on reservation is illegal (assertion).
  - release_en_i bits on FREE entries are ignored.

Test Plan:
- Reset, then reserve ID 2 with len 3 -> rsv_iid_o = 0, free_cnt_o = 7. Feed 4 beats 0xA0..0xA3 with release_en_i = 0 -> out_valid_o stays 0. Set release_en_i[0] -> 4 beats out in order, last with out_last_o = 1, released_addr_onehot_o = 0x01 on each beat, then free_cnt_o = 8.
- Reserve ID1 (iid 0) then ID1 (iid 1), each len 0. Send 0x11 then 0x22 on ID1 -> entry 0 holds 0x11 and entry 1 holds 0x22. Release 1 only -> 0x22 out first.
- Beat on ID3 with no reservation -> in_ready_o = 0 until ID3 is reserved, then accepted the same cycle ready rises.
- Fill all 8 entries -> rsv_ready_o = 0. Complete one release -> rsv_ready_o = 1 in the following cycle; new rsv_iid_o equals the freed index.
- Release entries 0 and 1 together, both len 3, with out_ready_i toggling every cycle -> all of entry 0's beats precede entry 1's; no interleave.
- Assert rst_i mid-burst after 2 of 4 beats sent -> the next cycle shows all reset values, and a fresh reservation gets iid 0.

Source files
------------

// File: rtl/simmem_rsp_bank_gen_if.sv
// Handshake bundle between the response bank and its surroundings.
// No latency of its own; carries combinational signals only.
// Backpressure is carried by the rsv/in/out ready signals.
interface simmem_rsp_bank_gen_if #(
   parameter int NumIds      = 4,
   parameter int Capacity    = 8,
   parameter int MaxBurstLen = 4,
   parameter int DataW       = 32
) ();
   localparam int IdW       = (NumIds > 1) ? $clog2(NumIds) : 1;
   localparam int IidW      = (Capacity > 1) ? $clog2(Capacity) : 1;
   localparam int BurstLenW = (MaxBurstLen > 1) ? $clog2(MaxBurstLen) : 1;

   logic                 rsv_valid_i;
   logic                 rsv_ready_o;
   logic [IdW-1:0]       rsv_id_i;
   logic [BurstLenW-1:0] rsv_burst_len_i;
   logic [IidW-1:0]      rsv_iid_o;
   logic [Capacity-1:0]  release_en_i;
   logic [Capacity-1:0]  released_addr_onehot_o;
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [IdW-1:0]       in_id_i;
   logic [DataW-1:0]     in_data_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [DataW-1:0]     out_data_o;
   logic                 out_last_o;
   logic [IidW:0]        free_cnt_o;

   modport slave (
      input  rsv_valid_i, rsv_id_i, rsv_burst_len_i, release_en_i,
             in_valid_i, in_id_i, in_data_i, out_ready_i,
      output rsv_ready_o, rsv_iid_o, released_addr_onehot_o, in_ready_o,
             out_valid_o, out_data_o, out_last_o, free_cnt_o
   );

   modport master (
      output rsv_valid_i, rsv_id_i, rsv_burst_len_i, release_en_i,
             in_valid_i, in_id_i, in_data_i, out_ready_i,
      input  rsv_ready_o, rsv_iid_o, released_addr_onehot_o, in_ready_o,
             out_valid_o, out_data_o, out_last_o, free_cnt_o
   );
endinterface

// File: rtl/simmem_rsp_bank_gen.sv
// Response bank: reserves burst entries, stores per-ID ordered beats, emits released bursts.
// Latency: a stored beat is readable the cycle after it is written.
// Backpressure: rsv stalls when full, in stalls without a matching open entry, out holds under !out_ready_i.
module simmem_rsp_bank_gen #(
   parameter int NumIds      = 4,
   parameter int Capacity    = 8,
   parameter int MaxBurstLen = 4,
   parameter int DataW       = 32
) (
   input logic clk_i,
   input logic rst_i,
   simmem_rsp_bank_gen_if.slave bus
);
   localparam int IdW       = (NumIds > 1) ? $clog2(NumIds) : 1;
   localparam int IidW      = (Capacity > 1) ? $clog2(Capacity) : 1;
   localparam int BurstLenW = (MaxBurstLen > 1) ? $clog2(MaxBurstLen) : 1;
   // write pointer must reach len+1 once the burst is complete
   localparam int PtrW      = $clog2(MaxBurstLen + 1);

   typedef enum logic [1:0] {ST_FREE, ST_RSV, ST_FILLED} ent_st_e;

   ent_st_e              st_q     [Capacity];
   ent_st_e              st_d     [Capacity];
   logic [IdW-1:0]       id_q     [Capacity];
   logic [IdW-1:0]       id_d     [Capacity];
   logic [IidW-1:0]      seq_q    [Capacity];
   logic [IidW-1:0]      seq_d    [Capacity];
   logic [BurstLenW-1:0] len_q    [Capacity];
   logic [BurstLenW-1:0] len_d    [Capacity];
   logic [PtrW-1:0]      wr_q     [Capacity];
   logic [PtrW-1:0]      wr_d     [Capacity];
   logic [PtrW-1:0]      rd_q     [Capacity];
   logic [PtrW-1:0]      rd_d     [Capacity];
   logic [IidW-1:0]      rsv_seq_q[NumIds];
   logic [IidW-1:0]      rsv_seq_d[NumIds];
   logic [IidW-1:0]      in_seq_q [NumIds];
   logic [IidW-1:0]      in_seq_d [NumIds];
   logic [DataW-1:0]     mem_q    [Capacity][MaxBurstLen];
   logic [DataW-1:0]     mem_d    [Capacity][MaxBurstLen];
   logic                 lock_q, lock_d;
   logic [IidW-1:0]      lock_idx_q, lock_idx_d;

   logic                 rsv_found, in_found, out_vld, out_last, rsv_hs, in_hs, out_hs;
   logic [IidW-1:0]      rsv_idx, in_idx, out_idx;
   logic [IidW:0]        busy_cnt;
   logic [BurstLenW-1:0] len_eff;

   function automatic logic [IidW-1:0] seq_inc(input logic [IidW-1:0] s);
      return (s == IidW'(Capacity - 1)) ? '0 : s + 1'b1;
   endfunction

   // Lowest free entry for reservation, occupancy count, and the open entry matching the incoming ID
   always_comb begin
      rsv_found = 1'b0;
      rsv_idx   = '0;
      busy_cnt  = '0;
      in_found  = 1'b0;
      in_idx    = '0;
      for (int e = 0; e < Capacity; e++) begin
         if (st_q[e] == ST_FREE) begin
            if (!rsv_found) begin
               rsv_found = 1'b1;
               rsv_idx   = IidW'(e);
            end
         end else begin
            busy_cnt = busy_cnt + 1'b1;
         end
         if (!in_found && st_q[e] != ST_FREE && id_q[e] == bus.in_id_i &&
             seq_q[e] == in_seq_q[bus.in_id_i] && wr_q[e] <= PtrW'(len_q[e])) begin
            in_found = 1'b1;
            in_idx   = IidW'(e);
         end
      end
   end

   // Output arbitration: a locked burst keeps the port until its last beat leaves
   always_comb begin
      out_vld = 1'b0;
      out_idx = lock_idx_q;
      if (lock_q) begin
         out_vld = rd_q[lock_idx_q] < wr_q[lock_idx_q];
      end else begin
         for (int e = 0; e < Capacity; e++) begin
            if (!out_vld && st_q[e] != ST_FREE && bus.release_en_i[e] && rd_q[e] < wr_q[e]) begin
               out_vld = 1'b1;
               out_idx = IidW'(e);
            end
         end
      end
      out_last = out_vld && (rd_q[out_idx] == PtrW'(len_q[out_idx]));
   end

   assign len_eff = (MaxBurstLen == 1) ? '0 : bus.rsv_burst_len_i;
   assign rsv_hs  = bus.rsv_valid_i && rsv_found;
   assign in_hs   = bus.in_valid_i && in_found;
   assign out_hs  = out_vld && bus.out_ready_i;

   assign bus.rsv_ready_o            = rsv_found;
   assign bus.rsv_iid_o              = rsv_idx;
   assign bus.in_ready_o             = in_found;
   assign bus.out_valid_o            = out_vld;
   assign bus.out_last_o             = out_last;
   assign bus.out_data_o             = mem_q[out_idx][rd_q[out_idx][BurstLenW-1:0]];
   assign bus.released_addr_onehot_o = out_hs ? (Capacity'(1) << out_idx) : '0;
   assign bus.free_cnt_o             = (IidW + 1)'(Capacity) - busy_cnt;

   // Next state: reservation, input write and output read each touch independent fields
   always_comb begin
      st_d       = st_q;
      id_d       = id_q;
      seq_d      = seq_q;
      len_d      = len_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      rsv_seq_d  = rsv_seq_q;
      in_seq_d   = in_seq_q;
      mem_d      = mem_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (rsv_hs) begin
         st_d[rsv_idx]             = ST_RSV;
         id_d[rsv_idx]             = bus.rsv_id_i;
         len_d[rsv_idx]            = len_eff;
         seq_d[rsv_idx]            = rsv_seq_q[bus.rsv_id_i];
         wr_d[rsv_idx]             = '0;
         rd_d[rsv_idx]             = '0;
         rsv_seq_d[bus.rsv_id_i]   = seq_inc(rsv_seq_q[bus.rsv_id_i]);
      end
      if (in_hs) begin
         mem_d[in_idx][wr_q[in_idx][BurstLenW-1:0]] = bus.in_data_i;
         wr_d[in_idx] = wr_q[in_idx] + 1'b1;
         if (wr_q[in_idx] == PtrW'(len_q[in_idx])) begin
            st_d[in_idx]           = ST_FILLED;
            in_seq_d[bus.in_id_i]  = seq_inc(in_seq_q[bus.in_id_i]);
         end
      end
      if (out_hs) begin
         rd_d[out_idx] = rd_q[out_idx] + 1'b1;
         if (out_last) begin
            st_d[out_idx] = ST_FREE;
         end
      end
      if (out_hs && out_last) begin
         lock_d = 1'b0;
      end else if (out_vld) begin
         lock_d     = 1'b1;
         lock_idx_d = out_idx;
      end
   end

   // Control state registers; reset frees every entry and drops any burst in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int e = 0; e < Capacity; e++) begin
            st_q[e]  <= ST_FREE;
            id_q[e]  <= '0;
            seq_q[e] <= '0;
            len_q[e] <= '0;
            wr_q[e]  <= '0;
            rd_q[e]  <= '0;
         end
         for (int i = 0; i < NumIds; i++) begin
            rsv_seq_q[i] <= '0;
            in_seq_q[i]  <= '0;
         end
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         st_q       <= st_d;
         id_q       <= id_d;
         seq_q      <= seq_d;
         len_q      <= len_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         rsv_seq_q  <= rsv_seq_d;
         in_seq_q   <= in_seq_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   // Payload storage; contents are meaningless until the owning entry is written
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Reservations longer than an entry can hold are a caller error
   always_ff @(posedge clk_i) begin
      if (!rst_i && rsv_hs) begin
         assert (MaxBurstLen == 1 || int'(bus.rsv_burst_len_i) < MaxBurstLen);
      end
   end
endmodule

// File: tb/tb_simmem_rsp_bank_gen.sv
module tb_simmem_rsp_bank_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] cap_dat [8];
   logic        cap_last[8];
   logic [7:0]  cap_oh  [8];

   simmem_rsp_bank_gen_if #(.NumIds(4), .Capacity(8), .MaxBurstLen(4), .DataW(32)) bus ();

   simmem_rsp_bank_gen #(.NumIds(4), .Capacity(8), .MaxBurstLen(4), .DataW(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reserve(input logic [1:0] id, input logic [1:0] len, input logic [2:0] exp_iid);
      bus.rsv_valid_i     = 1'b1;
      bus.rsv_id_i        = id;
      bus.rsv_burst_len_i = len;
      #1;
      chk("rsv_ready", bus.rsv_ready_o, 1);
      chk("rsv_iid", bus.rsv_iid_o, exp_iid);
      step();
      bus.rsv_valid_i = 1'b0;
   endtask

   task automatic feed(input logic [1:0] id, input logic [31:0] dat);
      bus.in_valid_i = 1'b1;
      bus.in_id_i    = id;
      bus.in_data_i  = dat;
      #1;
      chk("in_ready", bus.in_ready_o, 1);
      step();
      bus.in_valid_i = 1'b0;
   endtask

   task automatic pop_chk(input logic [31:0] dat, input logic last, input logic [7:0] oh);
      bus.out_ready_i = 1'b1;
      #1;
      chk("pop_valid", bus.out_valid_o, 1);
      chk("pop_data", bus.out_data_o, dat);
      chk("pop_last", bus.out_last_o, last);
      chk("pop_onehot", bus.released_addr_onehot_o, oh);
      step();
      bus.out_ready_i = 1'b0;
   endtask

   // Collect n beats with out_ready toggling; release_en switches to rel_next after the first beat
   task automatic drain(input int n, input logic [7:0] rel_next);
      int got = 0;
      for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
         bus.out_ready_i = ((cyc % 2) == 1);
         #1;
         if (bus.out_valid_o && bus.out_ready_i) begin
            cap_dat[got]  = bus.out_data_o;
            cap_last[got] = bus.out_last_o;
            cap_oh[got]   = bus.released_addr_onehot_o;
            got++;
         end
         step();
         if (got > 0) bus.release_en_i = rel_next;
      end
      bus.out_ready_i = 1'b0;
      chk("drain_count", got, n);
   endtask

   task automatic chk_reset_vals();
      chk("rst_rsv_ready", bus.rsv_ready_o, 1);
      chk("rst_in_ready", bus.in_ready_o, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_out_last", bus.out_last_o, 0);
      chk("rst_onehot", bus.released_addr_onehot_o, 0);
      chk("rst_free_cnt", bus.free_cnt_o, 8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rsv_valid_i     = 1'b0;
      bus.rsv_id_i        = '0;
      bus.rsv_burst_len_i = '0;
      bus.release_en_i    = '0;
      bus.in_valid_i      = 1'b0;
      bus.in_id_i         = 2'd2;
      bus.in_data_i       = '0;
      bus.out_ready_i     = 1'b0;
      step();
      step();
      chk_reset_vals();
      rst = 1'b0;
      step();

      // single 4-beat burst, held until released
      reserve(2'd2, 2'd3, 3'd0);
      chk("t1_free_cnt", bus.free_cnt_o, 7);
      for (int i = 0; i < 4; i++) feed(2'd2, 32'hA0 + i);
      bus.in_id_i = 2'd2;
      #1;
      chk("t1_in_ready_filled", bus.in_ready_o, 0);
      chk("t1_held", bus.out_valid_o, 0);
      step();
      chk("t1_still_held", bus.out_valid_o, 0);
      bus.release_en_i = 8'h01;
      for (int i = 0; i < 4; i++) pop_chk(32'hA0 + i, (i == 3), 8'h01);
      chk("t1_free_after", bus.free_cnt_o, 8);
      chk("t1_out_idle", bus.out_valid_o, 0);
      bus.release_en_i = 8'h00;

      // same ID, two bursts: in-order fill, out-of-order release
      reserve(2'd1, 2'd0, 3'd0);
      reserve(2'd1, 2'd0, 3'd1);
      feed(2'd1, 32'h11);
      feed(2'd1, 32'h22);
      bus.release_en_i = 8'h02;
      pop_chk(32'h22, 1'b1, 8'h02);
      bus.release_en_i = 8'h01;
      pop_chk(32'h11, 1'b1, 8'h01);
      bus.release_en_i = 8'h00;

      // unreserved ID is back-pressured until its reservation lands
      bus.in_valid_i = 1'b1;
      bus.in_id_i    = 2'd3;
      bus.in_data_i  = 32'h33;
      #1;
      chk("t3_no_rsv", bus.in_ready_o, 0);
      step();
      chk("t3_no_rsv2", bus.in_ready_o, 0);
      reserve(2'd3, 2'd0, 3'd0);
      bus.in_valid_i = 1'b1;
      chk("t3_ready_rises", bus.in_ready_o, 1);
      step();
      bus.in_valid_i = 1'b0;
      bus.release_en_i = 8'h01;
      pop_chk(32'h33, 1'b1, 8'h01);
      bus.release_en_i = 8'h00;

      // full bank; a freed entry becomes reservable only on the next cycle
      for (int i = 0; i < 8; i++) reserve(2'(i % 4), 2'd0, 3'(i));
      #1;
      chk("t4_full_ready", bus.rsv_ready_o, 0);
      chk("t4_full_cnt", bus.free_cnt_o, 0);
      feed(2'd3, 32'h44);
      bus.release_en_i = 8'h08;
      bus.out_ready_i  = 1'b1;
      #1;
      chk("t4_pop_data", bus.out_data_o, 32'h44);
      chk("t4_pop_onehot", bus.released_addr_onehot_o, 8'h08);
      chk("t4_not_free_yet", bus.rsv_ready_o, 0);
      step();
      bus.out_ready_i  = 1'b0;
      bus.release_en_i = 8'h00;
      #1;
      chk("t4_free_next", bus.rsv_ready_o, 1);
      chk("t4_iid_freed", bus.rsv_iid_o, 3);
      chk("t4_free_cnt", bus.free_cnt_o, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_rst_cnt", bus.free_cnt_o, 8);

      // two released bursts drained with toggling ready: no interleave
      reserve(2'd0, 2'd3, 3'd0);
      reserve(2'd1, 2'd3, 3'd1);
      for (int i = 0; i < 4; i++) feed(2'd0, 32'hB0 + i);
      for (int i = 0; i < 4; i++) feed(2'd1, 32'hC0 + i);
      bus.release_en_i = 8'h03;
      drain(8, 8'h03);
      for (int i = 0; i < 8; i++) begin
         chk("t5_dat", cap_dat[i], (i < 4) ? 32'hB0 + i : 32'hC0 + i - 4);
         chk("t5_last", cap_last[i], (i % 4) == 3);
         chk("t5_oh", cap_oh[i], (i < 4) ? 8'h01 : 8'h02);
      end
      bus.release_en_i = 8'h00;

      // lock holds entry 1 even when lower-index entry 0 becomes eligible mid-burst
      reserve(2'd0, 2'd3, 3'd0);
      reserve(2'd1, 2'd3, 3'd1);
      for (int i = 0; i < 4; i++) feed(2'd0, 32'hB0 + i);
      for (int i = 0; i < 4; i++) feed(2'd1, 32'hC0 + i);
      bus.release_en_i = 8'h02;
      drain(8, 8'h03);
      for (int i = 0; i < 8; i++) begin
         chk("t5b_dat", cap_dat[i], (i < 4) ? 32'hC0 + i : 32'hB0 + i - 4);
         chk("t5b_oh", cap_oh[i], (i < 4) ? 8'h02 : 8'h01);
      end

      // reset in the middle of an outgoing burst
      bus.release_en_i = 8'h00;
      reserve(2'd2, 2'd3, 3'd0);
      for (int i = 0; i < 4; i++) feed(2'd2, 32'hD0 + i);
      bus.release_en_i = 8'h01;
      pop_chk(32'hD0, 1'b0, 8'h01);
      pop_chk(32'hD1, 1'b0, 8'h01);
      rst = 1'b1;
      bus.in_id_i = 2'd2;
      step();
      chk_reset_vals();
      rst = 1'b0;
      bus.release_en_i = 8'h00;
      reserve(2'd0, 2'd0, 3'd0);
      feed(2'd0, 32'hE0);
      bus.release_en_i = 8'h01;
      pop_chk(32'hE0, 1'b1, 8'h01);
      bus.release_en_i = 8'h00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
